// File: rtl/icc_branch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : icc_branch_unit_if
// Brief    : Bicc branch request / delay-slot / PC-redirect bundle
// Revision : 1.0 - initial release
// ============================================================================
interface icc_branch_unit_if #(
  parameter int PC_W   = 32,
  parameter int DISP_W = 22
);
  logic              br_valid;
  logic              br_ready;
  logic [3:0]        br_cond;
  logic              br_annul;
  logic [DISP_W-1:0] br_disp;
  logic [PC_W-1:0]   br_pc;
  logic              ds_valid;
  logic              redirect;
  logic              taken;
  logic [PC_W-1:0]   target;
  logic              annul_ds;

  modport master (
    output br_valid, br_cond, br_annul, br_disp, br_pc, ds_valid,
    input  br_ready, redirect, taken, target, annul_ds
  );

  modport slave (
    input  br_valid, br_cond, br_annul, br_disp, br_pc, ds_valid,
    output br_ready, redirect, taken, target, annul_ds
  );
endinterface
`default_nettype wire

// File: rtl/icc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : icc_branch_unit
// Brief    : SPARC V8 icc holder, Bicc resolver and delay-slot sequencer
// Revision : 1.0 - initial release
// ============================================================================
module icc_branch_unit #(
  parameter int PC_W   = 32,
  parameter int DISP_W = 22
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  input  wire logic       alu_valid,
  input  wire logic [5:0] alu_op,
  input  wire logic       alu_n,
  input  wire logic       alu_z,
  input  wire logic       alu_v,
  input  wire logic       alu_c,
  input  wire logic       wr_icc_en,
  input  wire logic [3:0] wr_icc,
  output logic [3:0]      icc,
  output logic            cin_out,
  icc_branch_unit_if.slave bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_EVAL  = 2'd1;
  localparam logic [1:0] c_DELAY = 2'd2;
  localparam logic [3:0] c_BA    = 4'h8;

  logic [1:0]        r_state;
  logic [3:0]        r_icc;
  logic [3:0]        r_cond;
  logic              r_annul;
  logic [DISP_W-1:0] r_disp;
  logic [PC_W-1:0]   r_pc;
  logic              r_taken;
  logic              r_redirect;
  logic [PC_W-1:0]   r_target;

  logic              w_n, w_z, w_v, w_c, w_lt;
  logic              w_cond_true;
  logic [PC_W-1:0]   w_target;

  assign {w_n, w_z, w_v, w_c} = r_icc;
  assign w_lt = w_n ^ w_v;

  always_comb begin
    w_cond_true = 1'b0;
    case (r_cond)
      4'h0: w_cond_true = 1'b0;
      4'h1: w_cond_true = w_z;
      4'h2: w_cond_true = w_z | w_lt;
      4'h3: w_cond_true = w_lt;
      4'h4: w_cond_true = w_c | w_z;
      4'h5: w_cond_true = w_c;
      4'h6: w_cond_true = w_n;
      4'h7: w_cond_true = w_v;
      4'h8: w_cond_true = 1'b1;
      4'h9: w_cond_true = ~w_z;
      4'hA: w_cond_true = ~(w_z | w_lt);
      4'hB: w_cond_true = ~w_lt;
      4'hC: w_cond_true = ~(w_c | w_z);
      4'hD: w_cond_true = ~w_c;
      4'hE: w_cond_true = ~w_n;
      4'hF: w_cond_true = ~w_v;
      default: w_cond_true = 1'b0;
    endcase
  end

  // Word displacement: sign-extend and scale by 4; wraps modulo 2^PC_W.
  assign w_target = r_pc + {{(PC_W-DISP_W-2){r_disp[DISP_W-1]}}, r_disp, 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= c_IDLE;
      r_icc      <= 4'h0;
      r_cond     <= 4'h0;
      r_annul    <= 1'b0;
      r_disp     <= '0;
      r_pc       <= '0;
      r_taken    <= 1'b0;
      r_redirect <= 1'b0;
      r_target   <= '0;
    end else begin
      // Direct write has priority over the ALU flag update.
      if (wr_icc_en) begin
        r_icc <= wr_icc;
      end else if (alu_valid && (alu_op[5:4] == 2'b01)) begin
        r_icc <= {alu_n, alu_z, alu_v, alu_c};
      end

      r_redirect <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (bus.br_valid) begin
            r_cond  <= bus.br_cond;
            r_annul <= bus.br_annul;
            r_disp  <= bus.br_disp;
            r_pc    <= bus.br_pc;
            r_state <= c_EVAL;
          end
        end
        c_EVAL: begin
          r_taken    <= w_cond_true;
          r_target   <= w_target;
          r_redirect <= w_cond_true;
          r_state    <= c_DELAY;
        end
        c_DELAY: begin
          if (bus.ds_valid) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign icc          = r_icc;
  assign cin_out      = r_icc[0];
  assign bus.br_ready = (r_state == c_IDLE);
  assign bus.redirect = r_redirect;
  assign bus.taken    = r_taken;
  assign bus.target   = r_target;
  assign bus.annul_ds = (r_state == c_DELAY) && r_annul &&
                        (!r_taken || (r_cond == c_BA));

endmodule
`default_nettype wire
